// File: rtl/if_prefetch.sv
// Instruction prefetch: loadable program memory feeding a QUEUE_DEPTH-entry {instruction, pc} queue for decode.
// Latency: a fetched entry is visible one edge after fetch; backpressure: i_ready low holds the head, fetch stalls when full.
module if_prefetch #(
    parameter  int PC_SIZE            = 32,
    parameter  int WORD_SIZE_IN_BYTES = 4,
    parameter  int MEM_SIZE_IN_WORDS  = 64,
    parameter  int QUEUE_DEPTH        = 4,
    localparam int BUS_SIZE           = 8 * WORD_SIZE_IN_BYTES,
    localparam int QAW                = $clog2(QUEUE_DEPTH),
    localparam int CW                 = QAW + 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_halt,
    input  logic                i_redirect,
    input  logic [PC_SIZE-1:0]  i_redirect_pc,
    input  logic                i_write_mem,
    input  logic                i_clear_mem,
    input  logic [BUS_SIZE-1:0] i_instruction,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [BUS_SIZE-1:0] o_instruction,
    output logic [PC_SIZE-1:0]  o_pc,
    output logic [PC_SIZE-1:0]  o_next_seq_pc,
    output logic                o_full_mem,
    output logic                o_empty_mem,
    output logic [CW-1:0]       o_queue_count,
    output logic                o_halted
);

    localparam int OFFS = $clog2(WORD_SIZE_IN_BYTES);
    localparam int MAW  = (MEM_SIZE_IN_WORDS > 1) ? $clog2(MEM_SIZE_IN_WORDS) : 1;
    localparam int LPW  = $clog2(MEM_SIZE_IN_WORDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BUS_SIZE-1:0] r_mem [MEM_SIZE_IN_WORDS];
    logic [LPW-1:0]      r_load_ptr;
    logic [PC_SIZE-1:0]  r_fetch_pc;
    logic [BUS_SIZE-1:0] r_q_instr [QUEUE_DEPTH];
    logic [PC_SIZE-1:0]  r_q_pc [QUEUE_DEPTH];
    logic [QAW-1:0]      r_rd_ptr;
    logic [QAW-1:0]      r_wr_ptr;
    logic [CW-1:0]       r_count;

    logic                w_clr;
    logic                w_full_mem;
    logic                w_load;
    logic                w_fetch_ok;
    logic                w_pop;
    logic                w_push;
    logic                w_run;
    logic                w_halted;
    logic [PC_SIZE-1:0]  w_index;
    logic [BUS_SIZE-1:0] w_mem_rd;

    assign w_clr      = i_reset || i_clear_mem;
    assign w_full_mem = (r_load_ptr == LPW'(MEM_SIZE_IN_WORDS));
    assign w_load     = i_write_mem && !w_full_mem;
    assign w_index    = r_fetch_pc >> OFFS;
    // Only words already loaded may be fetched; fetch resumes as loads advance the pointer.
    assign w_fetch_ok = (w_index < PC_SIZE'(r_load_ptr));
    assign w_mem_rd   = r_mem[w_index[MAW-1:0]];
    assign w_pop      = (r_count != '0) && i_ready && !i_redirect;
    assign w_push     = w_run && !i_halt && !i_redirect && w_fetch_ok &&
                        ((r_count < CW'(QUEUE_DEPTH)) || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_load_ptr <= '0;
            for (int i = 0; i < MEM_SIZE_IN_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_load) begin
            r_mem[r_load_ptr[MAW-1:0]] <= i_instruction;
            r_load_ptr                 <= r_load_ptr + LPW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_fetch_pc <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (i_redirect) begin
            r_fetch_pc <= i_redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + QAW'(1);
                r_fetch_pc <= r_fetch_pc + PC_SIZE'(WORD_SIZE_IN_BYTES);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + QAW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !w_clr) begin
            r_q_instr[r_wr_ptr] <= w_mem_rd;
            r_q_pc[r_wr_ptr]    <= r_fetch_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // HALT is left only through reset or clear, both handled in the state register.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_halt) w_state_nxt = S_HALT;
                     else if (i_enable) w_state_nxt = S_RUN;
            S_RUN:   if (i_halt) w_state_nxt = S_HALT;
                     else if (!i_enable) w_state_nxt = S_IDLE;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_run    = (r_state == S_RUN);
        w_halted = (r_state == S_HALT);
    end

    assign o_valid       = (r_count != '0);
    assign o_instruction = o_valid ? r_q_instr[r_rd_ptr] : '0;
    assign o_pc          = o_valid ? r_q_pc[r_rd_ptr] : '0;
    assign o_next_seq_pc = o_pc + PC_SIZE'(WORD_SIZE_IN_BYTES);
    assign o_full_mem    = w_full_mem;
    assign o_empty_mem   = (r_load_ptr == '0);
    assign o_queue_count = r_count;
    assign o_halted      = w_halted;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed scenarios plus random traffic against a queue-based reference model.
module tb_if_prefetch;
    localparam int MEMW = 64;
    localparam int QD   = 4;
    localparam int WB   = 4;
    localparam logic [102:0] RST_VEC = {1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1, 3'd0, 1'b0};

    logic        i_clk = 1'b0;
    logic        i_reset, i_enable, i_halt, i_redirect, i_write_mem, i_clear_mem, i_ready;
    logic [31:0] i_redirect_pc, i_instruction;
    logic        o_valid, o_full_mem, o_empty_mem, o_halted;
    logic [31:0] o_instruction, o_pc, o_next_seq_pc;
    logic [2:0]  o_queue_count;
    logic [102:0] got_vec;

    always #5 i_clk = ~i_clk;

    if_prefetch #(.PC_SIZE(32), .WORD_SIZE_IN_BYTES(4), .MEM_SIZE_IN_WORDS(64), .QUEUE_DEPTH(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_halt(i_halt),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .i_write_mem(i_write_mem),
        .i_clear_mem(i_clear_mem), .i_instruction(i_instruction), .i_ready(i_ready),
        .o_valid(o_valid), .o_instruction(o_instruction), .o_pc(o_pc),
        .o_next_seq_pc(o_next_seq_pc), .o_full_mem(o_full_mem), .o_empty_mem(o_empty_mem),
        .o_queue_count(o_queue_count), .o_halted(o_halted)
    );

    assign got_vec = {o_valid, o_instruction, o_pc, o_next_seq_pc, o_full_mem, o_empty_mem,
                      o_queue_count, o_halted};

    typedef struct packed { logic [31:0] instr; logic [31:0] pc; } entry_t;
    typedef enum int {M_IDLE, M_RUN, M_HALT} mstate_t;

    logic [31:0] m_mem [MEMW];
    int          m_lp;
    logic [31:0] m_fpc;
    entry_t      m_q[$];
    mstate_t     m_st;
    logic [31:0] words [MEMW];
    int          errors = 0;
    int          checks = 0;

    // Reference model: memory array, load count, fetch address and an ordered queue of entries.
    task automatic model_step();
        entry_t e, d;
        bit     pop, push;
        if (i_reset || i_clear_mem) begin
            m_st = M_IDLE; m_fpc = '0; m_lp = 0; m_q.delete();
            foreach (m_mem[k]) m_mem[k] = '0;
            return;
        end
        pop  = (m_q.size() != 0) && i_ready;
        push = (m_st == M_RUN) && !i_halt && !i_redirect && ((m_fpc >> 2) < 32'(m_lp)) &&
               (m_q.size() < QD || pop);
        e = '0;
        if (push) begin
            e.instr = m_mem[m_fpc >> 2];
            e.pc    = m_fpc;
        end
        if (i_write_mem && m_lp < MEMW) begin
            m_mem[m_lp] = i_instruction;
            m_lp++;
        end
        if (i_redirect) begin
            m_q.delete();
            m_fpc = i_redirect_pc;
        end else begin
            if (pop) d = m_q.pop_front();
            if (push) begin
                m_q.push_back(e);
                m_fpc = m_fpc + 32'(WB);
            end
        end
        if (i_halt && m_st != M_HALT) m_st = M_HALT;
        else if (m_st == M_IDLE && i_enable) m_st = M_RUN;
        else if (m_st == M_RUN && !i_enable) m_st = M_IDLE;
    endtask

    function automatic logic [102:0] exp_vec();
        logic v;
        logic [31:0] ins, pc;
        v   = (m_q.size() != 0);
        ins = v ? m_q[0].instr : 32'h0;
        pc  = v ? m_q[0].pc : 32'h0;
        return {v, ins, pc, pc + 32'd4, (m_lp == MEMW), (m_lp == 0), 3'(m_q.size()), (m_st == M_HALT)};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        i_reset = 0; i_enable = 0; i_halt = 0; i_redirect = 0; i_redirect_pc = '0;
        i_write_mem = 0; i_clear_mem = 0; i_instruction = '0; i_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1;
        tick();
        i_reset = 0;
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            i_write_mem = 1; i_instruction = words[i];
            tick();
        end
        i_write_mem = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_reset = 1;
        tick(); tick();
        i_reset = 0;
        checks++; if (got_vec !== RST_VEC) begin errors++; $display("FAIL reset_state got=%h exp=%h", got_vec, RST_VEC); end
        checks++; if (got_vec !== exp_vec()) begin errors++; $display("FAIL reset_model got=%h exp=%h", got_vec, exp_vec()); end
    endtask

    task automatic test_basic();
        logic        ev [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ep [5] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'h0};
        logic [31:0] ei [5];
        do_reset();
        words[0] = 32'hA0A0_0001; words[1] = 32'hB0B0_0002; words[2] = 32'hC0C0_0003;
        ei = '{32'h0, words[0], words[1], words[2], 32'h0};
        load_words(3);
        i_enable = 1; i_ready = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({o_valid, o_instruction, o_pc} !== {ev[c], ei[c], ep[c]}) begin
                errors++; $display("FAIL basic_seq c=%0d got v=%b i=%h pc=%h exp v=%b i=%h pc=%h",
                                   c, o_valid, o_instruction, o_pc, ev[c], ei[c], ep[c]);
            end
        end
        checks++; if (o_queue_count !== 3'd0) begin errors++; $display("FAIL basic_drained count=%0d exp=0", o_queue_count); end
        // A late load lets the stalled fetch resume on its own.
        i_write_mem = 1; i_instruction = 32'hD0D0_0004;
        tick();
        i_write_mem = 0;
        tick();
        checks++;
        if ({o_valid, o_instruction, o_pc} !== {1'b1, 32'hD0D0_0004, 32'hC}) begin
            errors++; $display("FAIL basic_resume got v=%b i=%h pc=%h exp v=1 i=d0d00004 pc=c", o_valid, o_instruction, o_pc);
        end
    endtask

    task automatic test_backpressure();
        entry_t got[$];
        entry_t g;
        do_reset();
        for (int i = 0; i < 8; i++) words[i] = $urandom;
        load_words(8);
        i_enable = 1; i_ready = 0;
        for (int c = 0; c < 6; c++) tick();
        checks++;
        if ({o_queue_count, o_pc, o_instruction} !== {3'd4, 32'h0, words[0]}) begin
            errors++; $display("FAIL bp_saturate count=%0d pc=%h i=%h exp count=4 pc=0 i=%h", o_queue_count, o_pc, o_instruction, words[0]);
        end
        i_ready = 1;
        for (int c = 0; c < 20; c++) begin
            if (o_valid) begin
                g.instr = o_instruction; g.pc = o_pc;
                got.push_back(g);
            end
            tick();
            checks++; if (got_vec !== exp_vec()) begin errors++; $display("FAIL bp_model c=%0d got=%h exp=%h", c, got_vec, exp_vec()); end
        end
        checks++; if (got.size() != 8) begin errors++; $display("FAIL bp_pop_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== {words[i], 32'(i * 4)}) begin
                errors++; $display("FAIL bp_order i=%0d got=%h@%h exp=%h@%h", i, got[i].instr, got[i].pc, words[i], i * 4);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 8; i++) words[i] = $urandom;
        load_words(8);
        i_enable = 1; i_ready = 0;
        for (int c = 0; c < 5; c++) tick();
        checks++; if (o_queue_count !== 3'd4) begin errors++; $display("FAIL redir_prefill count=%0d exp=4", o_queue_count); end
        i_redirect = 1; i_redirect_pc = 32'h14;
        tick();
        i_redirect = 0;
        checks++;
        if ({o_queue_count, o_valid} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL redir_flush count=%0d v=%b exp count=0 v=0", o_queue_count, o_valid);
        end
        tick();
        checks++;
        if ({o_valid, o_pc, o_next_seq_pc, o_instruction} !== {1'b1, 32'h14, 32'h18, words[5]}) begin
            errors++; $display("FAIL redir_target got v=%b pc=%h nxt=%h i=%h exp v=1 pc=14 nxt=18 i=%h",
                               o_valid, o_pc, o_next_seq_pc, o_instruction, words[5]);
        end
        i_ready = 1;
        tick();
        checks++;
        if ({o_pc, o_instruction} !== {32'h18, words[6]}) begin
            errors++; $display("FAIL redir_follow got pc=%h i=%h exp pc=18 i=%h", o_pc, o_instruction, words[6]);
        end
    endtask

    task automatic test_mem_full();
        do_reset();
        for (int i = 0; i < MEMW; i++) words[i] = $urandom;
        for (int i = 0; i < MEMW; i++) begin
            i_write_mem = 1; i_instruction = words[i];
            tick();
            if (i == MEMW - 2) begin
                checks++; if (o_full_mem !== 1'b0) begin errors++; $display("FAIL full_early got=%b exp=0", o_full_mem); end
            end
        end
        checks++; if (o_full_mem !== 1'b1) begin errors++; $display("FAIL full_at_64 got=%b exp=1", o_full_mem); end
        i_instruction = ~words[MEMW-1];
        tick();
        i_write_mem = 0;
        checks++;
        if ({o_full_mem, o_empty_mem} !== 2'b10) begin
            errors++; $display("FAIL full_drop full=%b empty=%b exp full=1 empty=0", o_full_mem, o_empty_mem);
        end
        i_enable = 1; i_redirect = 1; i_redirect_pc = 32'hFC;
        tick();
        i_redirect = 0;
        tick();
        checks++;
        if ({o_instruction, o_pc, o_next_seq_pc} !== {words[MEMW-1], 32'hFC, 32'h100}) begin
            errors++; $display("FAIL full_last_word got i=%h pc=%h nxt=%h exp i=%h pc=fc nxt=100",
                               o_instruction, o_pc, o_next_seq_pc, words[MEMW-1]);
        end
        i_ready = 1;
        tick();
        checks++;
        if ({o_valid, o_queue_count} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL full_no_overrun v=%b count=%0d exp v=0 count=0", o_valid, o_queue_count);
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 8; i++) words[i] = $urandom;
        load_words(8);
        i_enable = 1; i_ready = 0;
        for (int c = 0; c < 3; c++) tick();
        checks++; if (o_queue_count !== 3'd2) begin errors++; $display("FAIL halt_prefill count=%0d exp=2", o_queue_count); end
        i_halt = 1;
        tick();
        i_halt = 0;
        checks++;
        if ({o_halted, o_queue_count, o_pc} !== {1'b1, 3'd2, 32'h0}) begin
            errors++; $display("FAIL halt_enter halted=%b count=%0d pc=%h exp halted=1 count=2 pc=0", o_halted, o_queue_count, o_pc);
        end
        i_ready = 1;
        tick();
        checks++;
        if ({o_queue_count, o_pc, o_instruction} !== {3'd1, 32'h4, words[1]}) begin
            errors++; $display("FAIL halt_drain1 count=%0d pc=%h i=%h exp count=1 pc=4 i=%h", o_queue_count, o_pc, o_instruction, words[1]);
        end
        tick(); tick();
        checks++;
        if ({o_valid, o_queue_count, o_halted} !== {1'b0, 3'd0, 1'b1}) begin
            errors++; $display("FAIL halt_no_push v=%b count=%0d halted=%b exp v=0 count=0 halted=1", o_valid, o_queue_count, o_halted);
        end
        i_clear_mem = 1;
        tick();
        i_clear_mem = 0;
        checks++;
        if ({o_halted, o_empty_mem, o_valid} !== 3'b010) begin
            errors++; $display("FAIL halt_clear halted=%b empty=%b v=%b exp halted=0 empty=1 v=0", o_halted, o_empty_mem, o_valid);
        end
        tick();
        checks++; if (got_vec !== exp_vec()) begin errors++; $display("FAIL halt_after_clear got=%h exp=%h", got_vec, exp_vec()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) words[i] = $urandom;
        load_words(8);
        i_enable = 1; i_ready = 0;
        for (int c = 0; c < 6; c++) tick();
        checks++; if (o_queue_count !== 3'd4) begin errors++; $display("FAIL rstmid_prefill count=%0d exp=4", o_queue_count); end
        i_reset = 1; i_write_mem = 1; i_instruction = 32'hDEAD_BEEF; i_redirect = 1; i_redirect_pc = 32'h20; i_ready = 1;
        tick();
        checks++; if (got_vec !== RST_VEC) begin errors++; $display("FAIL rstmid_state got=%h exp=%h", got_vec, RST_VEC); end
        idle_inputs();
        tick();
        checks++; if (got_vec !== RST_VEC) begin errors++; $display("FAIL rstmid_quiet got=%h exp=%h", got_vec, RST_VEC); end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 299);
            i_reset       = (r == 0);
            i_clear_mem   = (r == 1) || (m_st == M_HALT && $urandom_range(0, 15) == 0);
            i_halt        = ($urandom_range(0, 79) == 0);
            i_enable      = ($urandom_range(0, 9) != 0);
            i_ready       = ($urandom_range(0, 2) != 0);
            i_redirect    = ($urandom_range(0, 19) == 0);
            i_redirect_pc = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 90)) : (32'($urandom_range(0, 22)) << 2);
            i_write_mem   = !i_redirect && ($urandom_range(0, 2) == 0);
            i_instruction = $urandom;
            tick();
            checks++; if (got_vec !== exp_vec()) begin errors++; $display("FAIL random c=%0d got=%h exp=%h", c, got_vec, exp_vec()); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m_st = M_IDLE; m_fpc = '0; m_lp = 0;
        foreach (m_mem[k]) m_mem[k] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_mem_full();
        test_halt();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
